// File: rtl/drum_mul_seq.sv
// Sequenced DRUM approximate multiplier: leading-one detection, K-bit unbiased
// mantissas, K-step shift-add multiply, then a left shift back to full scale.
module drum_mul_seq #(
    parameter int N = 16,
    parameter int K = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p
);

    localparam int SW = $clog2(N + 1);
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOD,
        MUL,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    ra, rb;
    logic [K-1:0]    ma, mb;
    logic [SW-1:0]   sa, sb;
    logic [2*K-1:0]  acc;
    logic [CW-1:0]   cnt;

    logic [SW-1:0]   ta, tb;
    logic [K-1:0]    ma_n, mb_n;
    logic [SW-1:0]   sa_n, sb_n;
    logic [2*N-1:0]  accx;
    logic [SW:0]     ssum;
    logic [2*K-1:0]  addend;

    function automatic logic [SW-1:0] lead_one(input logic [N-1:0] x);
        logic [SW-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (x[i]) t = SW'(i);
        end
        return t;
    endfunction

    // Operands below 2^K keep all their bits and are never shifted.
    function automatic logic [SW-1:0] shamt(input logic [SW-1:0] t);
        return (t < SW'(K)) ? '0 : (t - SW'(K - 1));
    endfunction

    function automatic logic [K-1:0] mant(input logic [N-1:0] x, input logic [SW-1:0] t);
        if (t < SW'(K))
            return x[K-1:0];
        return K'(x >> shamt(t)) | K'(1);
    endfunction

    always_comb begin
        ta   = lead_one(ra);
        tb   = lead_one(rb);
        ma_n = mant(ra, ta);
        mb_n = mant(rb, tb);
        sa_n = shamt(ta);
        sb_n = shamt(tb);
        accx = '0;
        accx[2*K-1:0] = acc;
        ssum = {1'b0, sa} + {1'b0, sb};
        addend = (2*K)'(ma) << cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p         <= '0;
            ra        <= '0;
            rb        <= '0;
            ma        <= '0;
            mb        <= '0;
            sa        <= '0;
            sb        <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra       <= a;
                        rb       <= b;
                        in_ready <= 1'b0;
                        state    <= LOD;
                    end
                end
                LOD: begin
                    if (ra == '0 || rb == '0) begin
                        p         <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ma    <= ma_n;
                        mb    <= mb_n;
                        sa    <= sa_n;
                        sb    <= sb_n;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (mb[cnt])
                        acc <= acc + addend;
                    if (cnt == CW'(K - 1)) begin
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    p         <= accx << ssum;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_mul_seq.sv
// Self-checking bench for drum_mul_seq: directed table, handshake/reset
// sequences and random operands against an arithmetic DRUM reference.
module tb_drum_mul_seq;

    localparam int N = 16;
    localparam int K = 6;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;

    int tests;
    int fails;

    drum_mul_seq #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        int             lat;
    } vec_t;

    vec_t tbl[7];

    function automatic int msb_pos(input longint unsigned x);
        int t;
        t = 0;
        while ((x >> (t + 1)) != 0) t++;
        return t;
    endfunction

    function automatic longint unsigned drum_ref(input longint unsigned x, input longint unsigned y);
        longint unsigned mx, my;
        int sx, sy;
        if (x == 0 || y == 0) return 0;
        if (x < (64'd1 << K)) begin mx = x; sx = 0; end
        else begin sx = msb_pos(x) - K + 1; mx = (x >> sx) | 64'd1; end
        if (y < (64'd1 << K)) begin my = y; sy = 0; end
        else begin sy = msb_pos(y) - K + 1; my = (y >> sy) | 64'd1; end
        return (mx * my) << (sx + sy);
    endfunction

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Issue one operation with out_ready high; checks result and edge latency.
    task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                          input longint unsigned exp_p, input int exp_lat, input string nm);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        check({nm, " ready"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = xa;
        b         = xb;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        check({nm, " p"}, p, exp_p);
        check({nm, " latency"}, lat, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        logic [2*N-1:0] hold;
        int accepts[$];
        int cyc;
        int w;

        tests = 0;
        fails = 0;
        tbl[0] = '{a: 16'd5,     b: 16'd7,     p: 32'd35,         lat: K + 2};
        tbl[1] = '{a: 16'd63,    b: 16'd63,    p: 32'd3969,       lat: K + 2};
        tbl[2] = '{a: 16'd1000,  b: 16'd3,     p: 32'd3024,       lat: K + 2};
        tbl[3] = '{a: 16'd64,    b: 16'd1,     p: 32'd66,         lat: K + 2};
        tbl[4] = '{a: 16'd65535, b: 16'd65535, p: 32'd4161798144, lat: K + 2};
        tbl[5] = '{a: 16'd0,     b: 16'd12345, p: 32'd0,          lat: 1};
        tbl[6] = '{a: 16'd12345, b: 16'd0,     p: 32'd0,          lat: 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat, $sformatf("vec%0d", i));

        // Back-pressure, with in_valid pulses while busy.
        in_valid = 1'b1; a = 16'd1000; b = 16'd3; out_ready = 1'b0;
        @(negedge clk);
        a = 16'd9; b = 16'd9;
        w = 0;
        while (!out_valid && w < 50) begin
            check("busy in_ready", in_ready, 0);
            @(negedge clk); w++;
        end
        in_valid = 1'b0;
        check("bp first p", p, 3024);
        hold = p;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp p stable", p, hold);
            check("bp in_ready", in_ready, 0);
            check("bp out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", out_valid, 0);
        check("release in_ready", in_ready, 1);
        check("p kept", p, 3024);

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1; a = 16'd64; b = 16'd1;
        for (cyc = 0; cyc < 45; cyc++) begin
            if (in_ready) accepts.push_back(cyc);
            if (out_valid) check("b2b p", p, 66);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b accept count", accepts.size(), 5);
        for (int i = 1; i < accepts.size(); i++)
            check("b2b interval", accepts[i] - accepts[i-1], K + 4);
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        check("b2b drain", in_ready, 1);

        // Asynchronous reset in the middle of MUL.
        in_valid = 1'b1; a = 16'd5; b = 16'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset p nonzero", (p != 0), 1);
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst p", p, 0);
        check("async rst in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd5, 16'd7, 35, K + 2, "post-reset");

        // Random operands, some narrowed to hit the exact region and zero.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            int wa, wb;
            wa = $urandom_range(0, N);
            wb = $urandom_range(0, N);
            ra = N'($urandom) & N'((32'd1 << wa) - 1);
            rb = N'($urandom) & N'((32'd1 << wb) - 1);
            run_op(ra, rb, drum_ref(ra, rb), (ra == 0 || rb == 0) ? 1 : K + 2,
                   $sformatf("rand%0d a=%0d b=%0d", i, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/drum_mul_seq.md
# drum_mul_seq

Multi-cycle DRUM (Dynamic Range Unbiased Multiplier) controller and datapath. It accepts two unsigned operands over a valid/ready handshake and locates each operand's leading one. It truncates each operand to a K-bit unbiased mantissa and multiplies the mantissas with a K-step shift-add sequence. It then returns the left-shifted approximate product over a second valid/ready handshake, and sits between an operand source and a result consumer as the sequenced form of the combinational DRUM multiplier.

## Interface
- N, 16, operand width; N >= 2.
- K, 6, kept mantissa bits; 2 <= K <= N.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b present.
- in_ready  out  1  block can accept operands; high exactly when state is IDLE.
- a  in  N  unsigned multiplicand, sampled on input handshake.
- b  in  N  unsigned multiplier, sampled on input handshake.
- out_valid  out  1  p holds a completed result.
- out_ready  in  1  consumer accepts p.
- p  out  2N  unsigned approximate product.

## Operation
- States: IDLE, LOD, MUL, SHIFT, DONE.
- IDLE: if in_valid, register a, b and go to LOD. in_valid is ignored in all other states.
- LOD: for each operand x, t = index of the highest set bit, from a full priority encoder.
  - If x < 2^K: mantissa m = x[K-1:0] and shift s = 0, which gives an exact result for that operand.
  - Otherwise: m = x[t:t-K+1] with m[0] forced to 1, and s = t-K+1.
  - If a == 0 or b == 0: p <= 0, out_valid <= 1, go to DONE.
  - Otherwise: store ma, mb, sa, sb, clear the 2K-bit accumulator and bit counter, go to MUL.
- MUL: for counter i = 0..K-1, if mb[i] then acc <= acc + (ma << i). Go to SHIFT after i = K-1.
- SHIFT: p <= zero-extend(acc) << (sa + sb), out_valid <= 1, go to DONE.
- Width rules: acc is 2K bits and cannot overflow. sa + sb <= 2(N-K), so the shifted value always fits in 2N bits and no saturation is needed.
- DONE: hold p and out_valid until out_ready. On out_valid && out_ready: out_valid <= 0, go to IDLE.
- p keeps its last value after out_valid drops, until it is overwritten by the next result.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, p 0, acc 0, counter 0.
- Latency for nonzero operands (input handshake at edge E0):
  - E1: LOD.
  - E2..E(K+1): the K MUL steps.
  - E(K+2): SHIFT.
  - out_valid is high after E(K+2), which is K+2 cycles (8 at defaults).
- Latency for a zero operand: out_valid is high after E1, which is 1 cycle.
- Throughput:
  - Output handshake at the first edge with out_valid high returns the block to IDLE.
  - The next input can be accepted one edge later.
  - Minimum issue interval is K+4 cycles.
- Back-pressure: with out_ready low, the block stays in DONE indefinitely with p stable and in_ready low.
- Asynchronous reset mid-operation discards the in-flight operation and forces all reset values immediately.
- No partial result is ever presented.

## Test plan
- Exact region: a=5, b=7 -> p=35 after 8 cycles; a=63, b=63 -> p=3969.
- Truncation: a=1000, b=3 -> mantissa 63, shift 4 -> p=3024; a=64, b=1 -> p=66 (boundary t=K, LSB forced).
- Maximum: a=b=65535 -> p=4161798144 (63*63<<20), with no overflow in 2N bits.
- Zero: a=0, b=12345 -> p=0 and out_valid 1 cycle after acceptance. Also check b=0.
- Handshake:
  - Hold out_ready low 20 cycles -> p stable, in_ready 0.
  - in_valid pulses while busy are ignored.
  - Back-to-back in_valid gives one accept every 10 cycles with out_ready tied high.
- Reset: assert rst_n low during MUL -> out_valid 0, p 0, in_ready 1 immediately. The next operation a=5, b=7 then returns 35.
